// File: rtl/b2gfifo_bus_master.sv
// Single-outstanding bus initiator for the B2G FIFO register bus.
// Valid/ready command in, enable/write/read strobes out, valid/ready response back.
module b2gfifo_bus_master #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [1:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_rdata,
   output logic       rsp_err,
   output logic       enable,
   output logic       write,
   output logic       read,
   output logic [1:0] addr,
   output logic [7:0] wdata,
   input  logic [7:0] rdata,
   input  logic       resp,
   output logic       stray_resp,
   output logic [1:0] state_dbg
);

   // Handshake: a transfer happens on a rising edge where valid && ready;
   // valid holds its payload stable until then, ready never depends on valid.

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Counter value on the edge that completes the TIMEOUT-th enable cycle.
   localparam logic [7:0] CNT_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic       started_q;
   logic       write_q;
   logic [1:0] addr_q;
   logic [7:0] wdata_q;
   logic [7:0] rdata_q;
   logic       err_q;
   logic [7:0] cnt_q;
   logic       stray_q;
   logic       accept;
   logic       timeout_hit;

   assign accept      = (state_q == IDLE) && started_q && cmd_valid;
   assign timeout_hit = (TIMEOUT != 0) && !resp && (cnt_q == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = ACCESS;
         ACCESS:  if (resp || timeout_hit) state_d = DONE;
         DONE:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Everything is decoded from registers, so all outputs drop to 0 the moment reset asserts.
   always_comb begin
      cmd_ready  = (state_q == IDLE) && started_q;
      enable     = (state_q == ACCESS);
      write      = enable && write_q;
      read       = enable && !write_q;
      addr       = enable ? addr_q : 2'd0;
      wdata      = enable ? wdata_q : 8'd0;
      rsp_valid  = (state_q == DONE);
      rsp_err    = rsp_valid && err_q;
      rsp_rdata  = rsp_valid ? rdata_q : 8'd0;
      stray_resp = stray_q;
      state_dbg  = state_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         started_q <= 1'b0;
         write_q   <= 1'b0;
         addr_q    <= 2'd0;
         wdata_q   <= 8'd0;
         rdata_q   <= 8'd0;
         err_q     <= 1'b0;
         cnt_q     <= 8'd0;
         stray_q   <= 1'b0;
      end else begin
         started_q <= 1'b1;
         if (resp && (state_q != ACCESS)) stray_q <= 1'b1;
         if (accept) begin
            write_q <= cmd_write;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_write ? cmd_wdata : 8'd0;
            cnt_q   <= 8'd0;
         end else if (state_q == ACCESS) begin
            // resp takes priority over a timeout landing on the same edge
            if (resp) begin
               rdata_q <= write_q ? 8'd0 : rdata;
               err_q   <= 1'b0;
            end else if (timeout_hit) begin
               rdata_q <= 8'd0;
               err_q   <= 1'b1;
            end else if (cnt_q != 8'hFF) begin
               cnt_q <= cnt_q + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_b2gfifo_bus_master.sv
// Directed bench for b2gfifo_bus_master: main instance at default TIMEOUT,
// plus TIMEOUT=4 and TIMEOUT=0 instances sharing a second stimulus port.
module tb_b2gfifo_bus_master;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_write, rsp_ready, resp;
   logic [1:0] cmd_addr;
   logic [7:0] cmd_wdata, rdata;
   logic       cmd_ready, rsp_valid, rsp_err, enable, write, read, stray_resp;
   logic [7:0] rsp_rdata, wdata;
   logic [1:0] addr, state_dbg;

   logic       c2_valid, c2_write, c2_rready, c2_resp;
   logic [1:0] c2_addr;
   logic [7:0] c2_wdata, c2_rdata;
   logic       t_cmd_ready, t_rsp_valid, t_rsp_err, t_enable, t_write, t_read, t_stray;
   logic [7:0] t_rsp_rdata, t_wdata;
   logic [1:0] t_addr, t_state;
   logic       z_cmd_ready, z_rsp_valid, z_rsp_err, z_enable, z_write, z_read, z_stray;
   logic [7:0] z_rsp_rdata, z_wdata;
   logic [1:0] z_addr, z_state;

   int         n_vec = 0;
   int         n_err = 0;
   int         en_main = 0;
   int         en_t = 0;
   int         base;
   int         lows;
   logic [7:0] exp_q[$];

   b2gfifo_bus_master dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .enable(enable), .write(write), .read(read), .addr(addr), .wdata(wdata),
      .rdata(rdata), .resp(resp), .stray_resp(stray_resp), .state_dbg(state_dbg)
   );

   b2gfifo_bus_master #(.TIMEOUT(4)) dut_t (
      .clk(clk), .rst_n(rst_n), .cmd_valid(c2_valid), .cmd_ready(t_cmd_ready),
      .cmd_write(c2_write), .cmd_addr(c2_addr), .cmd_wdata(c2_wdata),
      .rsp_valid(t_rsp_valid), .rsp_ready(c2_rready), .rsp_rdata(t_rsp_rdata), .rsp_err(t_rsp_err),
      .enable(t_enable), .write(t_write), .read(t_read), .addr(t_addr), .wdata(t_wdata),
      .rdata(c2_rdata), .resp(c2_resp), .stray_resp(t_stray), .state_dbg(t_state)
   );

   b2gfifo_bus_master #(.TIMEOUT(0)) dut_z (
      .clk(clk), .rst_n(rst_n), .cmd_valid(c2_valid), .cmd_ready(z_cmd_ready),
      .cmd_write(c2_write), .cmd_addr(c2_addr), .cmd_wdata(c2_wdata),
      .rsp_valid(z_rsp_valid), .rsp_ready(c2_rready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err),
      .enable(z_enable), .write(z_write), .read(z_read), .addr(z_addr), .wdata(z_wdata),
      .rdata(c2_rdata), .resp(c2_resp), .stray_resp(z_stray), .state_dbg(z_state)
   );

   // Clock
   always #5 clk = ~clk;

   // Enable-cycle counters: value seen at an edge is the level of the cycle just ended.
   always @(posedge clk) begin
      if (enable)   en_main++;
      if (t_enable) en_t++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Driver: present a command, wait (bounded) for ready, hand it over on one edge.
   task automatic send_cmd(input logic w, input logic [1:0] a, input logic [7:0] d,
                           input logic [7:0] exp_rd);
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (cmd_ready) break;
         tick();
      end
      chk("cmd_ready_before_accept", cmd_ready, 1'b1);
      tick();
      cmd_valid = 1'b0;
      exp_q.push_back(w ? 8'h00 : exp_rd);
   endtask

   // Scoreboard: compare the pending response with the oldest expected entry, then consume it.
   task automatic take_rsp(input string tag, input logic exp_err);
      logic [7:0] e;
      e = exp_q.pop_front();
      chk({tag, "_rsp_valid"}, rsp_valid, 1'b1);
      chk({tag, "_rsp_err"}, rsp_err, exp_err);
      chk({tag, "_rsp_rdata"}, rsp_rdata, e);
      chk({tag, "_enable_low"}, enable, 1'b0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk({tag, "_rsp_valid_clear"}, rsp_valid, 1'b0);
      chk({tag, "_cmd_ready_back"}, cmd_ready, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0;
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
      rsp_ready = 0; resp = 0; rdata = 0;
      c2_valid = 0; c2_write = 0; c2_addr = 2'd1; c2_wdata = 8'h00;
      c2_rready = 0; c2_resp = 0; c2_rdata = 8'hEE;

      // Reset
      repeat (2) @(posedge clk);
      #1;
      chk("reset_cmd_ready", cmd_ready, 1'b0);
      chk("reset_enable", enable, 1'b0);
      chk("reset_rsp_valid", rsp_valid, 1'b0);
      chk("reset_stray", stray_resp, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("release_cmd_ready_still_low", cmd_ready, 1'b0);
      tick();
      chk("release_cmd_ready_first_edge", cmd_ready, 1'b1);

      // Write addr=2 data=A5, zero-wait responder
      base = en_main;
      send_cmd(1'b1, 2'd2, 8'hA5, 8'h00);
      chk("wr_enable", enable, 1'b1);
      chk("wr_write", write, 1'b1);
      chk("wr_read", read, 1'b0);
      chk("wr_addr", addr, 2'd2);
      chk("wr_wdata", wdata, 8'hA5);
      chk("wr_cmd_ready_low", cmd_ready, 1'b0);
      resp = 1'b1;
      tick();
      resp = 1'b0;
      chk("wr_enable_cycles", en_main - base, 1);
      chk("wr_write_dropped", write, 1'b0);
      take_rsp("wr", 1'b0);

      // Read addr=2 returns A5; wdata must not leak onto the bus for reads
      send_cmd(1'b0, 2'd2, 8'h3C, 8'hA5);
      chk("rd_read", read, 1'b1);
      chk("rd_write", write, 1'b0);
      chk("rd_addr", addr, 2'd2);
      chk("rd_wdata_zero", wdata, 8'h00);
      rdata = 8'hA5;
      resp = 1'b1;
      tick();
      resp = 1'b0;
      rdata = 8'h00;
      take_rsp("rd", 1'b0);

      // Five wait states: bus held for six enable cycles
      base = en_main;
      send_cmd(1'b1, 2'd1, 8'h5A, 8'h00);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("ws_enable", enable, 1'b1);
         chk("ws_bus", {write, read, addr, wdata}, {1'b1, 1'b0, 2'd1, 8'h5A});
      end
      resp = 1'b1;
      tick();
      resp = 1'b0;
      chk("ws_enable_cycles", en_main - base, 6);
      take_rsp("ws", 1'b0);

      // Response backpressure for ten cycles
      send_cmd(1'b0, 2'd3, 8'h00, 8'h77);
      rdata = 8'h77;
      resp = 1'b1;
      tick();
      resp = 1'b0;
      rdata = 8'h00;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_hold", {rsp_valid, rsp_rdata, cmd_ready, enable}, {1'b1, 8'h77, 1'b0, 1'b0});
      end
      take_rsp("bp", 1'b0);

      // Stray resp while idle
      resp = 1'b1;
      tick();
      resp = 1'b0;
      chk("stray_set", stray_resp, 1'b1);
      chk("stray_no_rsp", rsp_valid, 1'b0);
      repeat (3) tick();
      chk("stray_sticky", stray_resp, 1'b1);
      chk("stray_cmd_ready", cmd_ready, 1'b1);

      // TIMEOUT=4 abort alongside TIMEOUT=0 which must hang for 300 cycles
      base = en_t;
      c2_valid = 1'b1;
      tick();
      c2_valid = 1'b0;
      chk("to_t_enable", t_enable, 1'b1);
      chk("to_z_enable", z_enable, 1'b1);
      repeat (3) begin
         tick();
         chk("to_t_enable_held", t_enable, 1'b1);
      end
      tick();
      chk("to_enable_cycles", en_t - base, 4);
      chk("to_t_rsp", {t_enable, t_rsp_valid, t_rsp_err, t_rsp_rdata}, {1'b0, 1'b1, 1'b1, 8'h00});
      lows = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (!z_enable) lows++;
      end
      chk("to0_enable_low_cycles", lows, 0);
      chk("to0_no_rsp", z_rsp_valid, 1'b0);
      chk("to_t_rsp_held", {t_rsp_valid, t_rsp_err}, 2'b11);
      c2_resp = 1'b1;
      tick();
      c2_resp = 1'b0;
      chk("to0_late_resp", {z_rsp_valid, z_rsp_err, z_rsp_rdata}, {1'b1, 1'b0, 8'hEE});
      c2_rready = 1'b1;
      tick();
      c2_rready = 1'b0;
      chk("to_both_idle", {t_cmd_ready, z_cmd_ready}, 2'b11);

      // resp on the TIMEOUT-th cycle wins over the abort
      base = en_t;
      c2_valid = 1'b1;
      tick();
      c2_valid = 1'b0;
      repeat (3) tick();
      c2_resp = 1'b1;
      tick();
      c2_resp = 1'b0;
      chk("race_enable_cycles", en_t - base, 4);
      chk("race_rsp", {t_rsp_valid, t_rsp_err, t_rsp_rdata}, {1'b1, 1'b0, 8'hEE});
      c2_rready = 1'b1;
      tick();
      c2_rready = 1'b0;

      // Asynchronous reset mid-transfer, then a normal transfer
      send_cmd(1'b0, 2'd3, 8'h00, 8'h00);
      void'(exp_q.pop_front());
      chk("mid_enable_before", enable, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_async", {enable, read, cmd_ready, rsp_valid, stray_resp}, 5'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_cmd_ready_low", cmd_ready, 1'b0);
      tick();
      chk("mid_cmd_ready_edge", cmd_ready, 1'b1);
      chk("mid_still_idle", {enable, rsp_valid}, 2'b00);
      send_cmd(1'b1, 2'd0, 8'h11, 8'h00);
      chk("post_bus", {enable, write, addr, wdata}, {1'b1, 1'b1, 2'd0, 8'h11});
      resp = 1'b1;
      tick();
      resp = 1'b0;
      take_rsp("post", 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
